npc_mem_bridge: RTL and testbench

NPC_MEM_BRIDGE -- requirements
Module: npc_mem_bridge

---
 rtl/npc_mem_bridge.sv | 178 +++++++++++++++++
 tb/tb_npc_mem_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_mem_bridge.sv
// Bridges MEM-stage loads/stores onto N_CH registered one-hot peripheral channels.
// Latency: request cycle T, ch_valid at T+1, rsp_valid at T+2 at best; illegal requests answer at T+1.
// Backpressure: stall holds the pipeline until the single RESP cycle; the wait is bounded by TIMEOUT.
module npc_mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int N_CH    = 4,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_wdata,
  output logic                stall,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [N_CH-1:0]     ch_valid,
  output logic                ch_wen,
  output logic [ADDR_W-1:0]   ch_addr,
  output logic [31:0]         ch_wdata,
  output logic [3:0]          ch_wstrb,
  input  logic [N_CH-1:0]     ch_ready,
  input  logic [N_CH*32-1:0]  ch_rdata
);

  localparam int SEL_W = $clog2(N_CH);
  // Last count value before the wait is declared expired.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [15:0]       wait_cnt;
  logic [SEL_W-1:0]  sel_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;

  logic [SEL_W-1:0]  req_sel;
  logic [1:0]        req_off;
  logic              req_illegal;
  logic [3:0]        req_strb;
  logic [31:0]       req_wdata_rep;
  logic [31:0]       sel_rdata;
  logic              sel_ready;

  assign req_sel   = req_addr[SEL_LSB +: SEL_W];
  assign req_off   = req_addr[1:0];
  assign sel_rdata = ch_rdata[{sel_q, 5'b00000} +: 32];
  assign sel_ready = ch_ready[sel_q];

  // Right-justify the addressed lane of the captured word and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] lane;
    lane = w >> {off, 3'b000};
    case (size)
      2'b00:   extend_load = uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   extend_load = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: extend_load = w;
    endcase
  endfunction

  // Decode request legality, byte strobes and lane-replicated store data.
  always_comb begin
    req_illegal   = 1'b0;
    req_strb      = 4'b1111;
    req_wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        req_strb      = 4'b0001 << req_off;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_illegal   = req_off[0];
        req_strb      = 4'b0011 << req_off;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_illegal   = |req_off;
      end
      default: begin
        req_illegal   = 1'b1;
      end
    endcase
  end

  // Freeze the pipeline from the request cycle until the response cycle.
  always_comb begin
    case (state)
      IDLE:    stall = req_valid;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Access sequencer: issue, wait for the selected channel or time out, respond for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      sel_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      ch_valid  <= '0;
      ch_wen    <= 1'b0;
      ch_addr   <= '0;
      ch_wdata  <= '0;
      ch_wstrb  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          if (req_valid) begin
            sel_q  <= req_sel;
            off_q  <= req_off;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            if (req_illegal) begin
              // Bad size or alignment never reaches a channel.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state    <= BUSY;
              wait_cnt <= '0;
              ch_valid <= {{(N_CH-1){1'b0}}, 1'b1} << req_sel;
              ch_wen   <= req_wen;
              ch_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              ch_wdata <= req_wdata_rep;
              ch_wstrb <= req_strb;
            end
          end
        end
        BUSY: begin
          // Ready wins over an expiring counter in the same cycle.
          if (sel_ready) begin
            state     <= RESP;
            ch_valid  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ch_wen ? 32'h0 : extend_load(sel_rdata, off_q, size_q, uns_q);
          end else if (wait_cnt == TO_LAST) begin
            state     <= RESP;
            ch_valid  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_cnt  <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          // The request still on the inputs here is the one just completed.
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mem_bridge.sv
// Directed bench for npc_mem_bridge: default instance plus a TIMEOUT=4 instance on shared inputs.
// Latency: checks cycle-exact response timing relative to the request cycle.
// Backpressure: drives ch_ready per scenario and counts stall cycles.
module tb_npc_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_wen, req_unsigned;
  logic [31:0]  req_addr, req_wdata;
  logic [1:0]   req_size;
  logic [3:0]   ch_ready;
  logic [127:0] ch_rdata;

  logic         stall, rsp_valid, rsp_err, ch_wen;
  logic [31:0]  rsp_rdata, ch_addr, ch_wdata;
  logic [3:0]   ch_valid, ch_wstrb;

  logic         to_stall, to_rsp_valid, to_rsp_err, to_ch_wen;
  logic [31:0]  to_rsp_rdata, to_ch_addr, to_ch_wdata;
  logic [3:0]   to_ch_valid, to_ch_wstrb;

  int errors = 0;
  int checks = 0;
  int n_rsp, n_chv, n_to_rsp;

  always #5 clk = ~clk;

  npc_mem_bridge dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ch_valid(ch_valid),
    .ch_wen(ch_wen), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
    .ch_ready(ch_ready), .ch_rdata(ch_rdata)
  );

  npc_mem_bridge #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata), .stall(to_stall),
    .rsp_valid(to_rsp_valid), .rsp_rdata(to_rsp_rdata), .rsp_err(to_rsp_err), .ch_valid(to_ch_valid),
    .ch_wen(to_ch_wen), .ch_addr(to_ch_addr), .ch_wdata(to_ch_wdata), .ch_wstrb(to_ch_wstrb),
    .ch_ready(ch_ready), .ch_rdata(ch_rdata)
  );

  // Advance one cycle and sample 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rsp_valid) n_rsp++;
    if (|ch_valid) n_chv++;
    if (to_rsp_valid) n_to_rsp++;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; ch_ready = '0; ch_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    n_rsp = 0; n_chv = 0; n_to_rsp = 0;
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd);
    req_wen = wen; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (ch_valid !== 4'b0) begin errors++; $display("FAIL reset_ch_valid: got %b want 0000", ch_valid); end
    checks++; if ({ch_wen, ch_addr, ch_wdata, ch_wstrb} !== 69'h0) begin errors++; $display("FAIL reset_ch_bus: got wen=%b addr=%h wdata=%h wstrb=%b want all 0", ch_wen, ch_addr, ch_wdata, ch_wstrb); end
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin errors++; $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h want all 0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b want 0", stall); end
    req_valid = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_follows_req: got %b want 1", stall); end
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_byte();
    do_reset();
    drive_req(1'b0, 32'h1000_0003, 2'b00, 1'b0, 32'h0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall_T: got %b want 1", stall); end
    tick();
    checks++; if (ch_valid !== 4'b0010) begin errors++; $display("FAIL lb_ch_valid: got %b want 0010", ch_valid); end
    checks++; if (ch_wstrb !== 4'b1000) begin errors++; $display("FAIL lb_wstrb: got %b want 1000", ch_wstrb); end
    checks++; if (ch_addr !== 32'h1000_0000 || ch_wen !== 1'b0) begin errors++; $display("FAIL lb_addr_wen: got %h/%b want 10000000/0", ch_addr, ch_wen); end
    ch_ready = 4'b0010;
    ch_rdata[63:32] = 32'h80FF_0000;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL lb_rsp_T2: got valid=%b err=%b want 1/0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", rsp_rdata); end
    checks++; if (ch_valid !== 4'b0 || stall !== 1'b0) begin errors++; $display("FAIL lb_resp_state: got ch_valid=%b stall=%b want 0000/0", ch_valid, stall); end
    ch_ready = '0;
    tick();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lb_rsp_one_cycle: got %b want 0", rsp_valid); end
  endtask

  task automatic test_store_half();
    int nstall;
    do_reset();
    drive_req(1'b1, 32'h2000_0002, 2'b01, 1'b0, 32'h0000_1234);
    #1;
    nstall = stall ? 1 : 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (stall) nstall++;
      if (k == 1) begin
        checks++; if (ch_valid !== 4'b0100 || ch_wen !== 1'b1) begin errors++; $display("FAIL sh_ch_valid: got %b wen=%b want 0100/1", ch_valid, ch_wen); end
        checks++; if (ch_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata: got %h want 12341234", ch_wdata); end
        checks++; if (ch_wstrb !== 4'b1100 || ch_addr !== 32'h2000_0000) begin errors++; $display("FAIL sh_wstrb_addr: got %b/%h want 1100/20000000", ch_wstrb, ch_addr); end
      end
      if (k == 6) begin
        checks++; if (ch_valid !== 4'b0100 || ch_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_hold: got %b/%h want 0100/12341234", ch_valid, ch_wdata); end
        ch_ready = 4'b0100;
        ch_rdata[95:64] = 32'hDEAD_BEEF;
      end
    end
    tick();
    if (stall) nstall++;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL sh_rsp: got valid=%b err=%b rdata=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (nstall !== 7) begin errors++; $display("FAIL sh_stall_cycles: got %0d want 7", nstall); end
    ch_ready = '0;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive_req(1'b0, 32'h0000_0006, 2'b10, 1'b0, 32'h0);
        1:       drive_req(1'b0, 32'h0000_0001, 2'b01, 1'b0, 32'h0);
        default: drive_req(1'b1, 32'h0000_0000, 2'b11, 1'b0, 32'hFFFF_FFFF);
      endcase
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ill%0d_stall: got %b want 1", i, stall); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL ill%0d_rsp: got valid=%b err=%b rdata=%h want 1/1/0", i, rsp_valid, rsp_err, rsp_rdata); end
      checks++; if (ch_valid !== 4'b0 || stall !== 1'b0) begin errors++; $display("FAIL ill%0d_nobus: got ch_valid=%b stall=%b want 0000/0", i, ch_valid, stall); end
      tick();
      req_valid = 1'b0;
    end
    checks++; if (n_chv !== 0 || n_rsp !== 3) begin errors++; $display("FAIL ill_totals: got chv=%0d rsp=%0d want 0/3", n_chv, n_rsp); end
  endtask

  task automatic test_timeout();
    int nv, rsp_at;
    logic e;
    logic [31:0] d;
    do_reset();
    drive_req(1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0);
    nv = 0; rsp_at = -1; e = 1'b0; d = 32'hX;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (to_ch_valid == 4'b0001) nv++;
      if (to_rsp_valid) begin
        rsp_at = k; e = to_rsp_err; d = to_rsp_rdata;
      end else if (rsp_at > 0) begin
        req_valid = 1'b0;
      end
    end
    checks++; if (nv !== 4) begin errors++; $display("FAIL to_ch_valid_cycles: got %0d want 4", nv); end
    checks++; if (rsp_at !== 5 || e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL to_abort: got at=%0d err=%b rdata=%h want 5/1/0", rsp_at, e, d); end
    checks++; if (n_to_rsp !== 1 || to_stall !== 1'b0 || to_ch_valid !== 4'b0) begin errors++; $display("FAIL to_idle: got rsp=%0d stall=%b ch_valid=%b want 1/0/0000", n_to_rsp, to_stall, to_ch_valid); end
    // Ready arriving on the cycle the counter expires still completes normally.
    do_reset();
    drive_req(1'b0, 32'h0000_0004, 2'b10, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) begin
        ch_ready = 4'b0001;
        ch_rdata[31:0] = 32'h5555_AAAA;
      end
    end
    tick();
    checks++; if (to_rsp_valid !== 1'b1 || to_rsp_err !== 1'b0 || to_rsp_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL to_edge_ready: got valid=%b err=%b rdata=%h want 1/0/5555aaaa", to_rsp_valid, to_rsp_err, to_rsp_rdata); end
    ch_ready = '0;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_req(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0);
    tick();
    checks++; if (ch_valid !== 4'b0001) begin errors++; $display("FAIL b2b_a_ch_valid: got %b want 0001", ch_valid); end
    ch_ready = 4'b0001;
    ch_rdata[31:0] = 32'hA5A5_0001;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_a_rsp: got %b/%h want 1/a5a50001", rsp_valid, rsp_rdata); end
    ch_ready = '0;
    tick();
    checks++; if (ch_valid !== 4'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_reissue: got ch_valid=%b rsp=%b want 0000/0", ch_valid, rsp_valid); end
    drive_req(1'b0, 32'h3000_0006, 2'b01, 1'b1, 32'h0);
    tick();
    checks++; if (ch_valid !== 4'b1000 || ch_wstrb !== 4'b1100) begin errors++; $display("FAIL b2b_b_ch: got %b/%b want 1000/1100", ch_valid, ch_wstrb); end
    ch_ready = 4'b1000;
    ch_rdata[127:96] = 32'h8765_4321;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_8765) begin errors++; $display("FAIL b2b_b_rsp: got %b/%h want 1/00008765", rsp_valid, rsp_rdata); end
    ch_ready = '0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checks++; if (n_rsp !== 2 || n_chv !== 2) begin errors++; $display("FAIL b2b_counts: got rsp=%0d chv=%0d want 2/2", n_rsp, n_chv); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    drive_req(1'b0, 32'h2000_0000, 2'b10, 1'b0, 32'h0);
    tick();
    checks++; if (ch_valid !== 4'b0100) begin errors++; $display("FAIL rb_ch_valid: got %b want 0100", ch_valid); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (ch_valid !== 4'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rb_async_clear: got ch_valid=%b rsp=%b want 0000/0", ch_valid, rsp_valid); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rb_stall_in_reset: got %b want 1", stall); end
    req_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    tick();
    checks++; if (n_rsp !== 0 || stall !== 1'b0) begin errors++; $display("FAIL rb_no_rsp: got rsp=%0d stall=%b want 0/0", n_rsp, stall); end
    drive_req(1'b0, 32'h2000_0001, 2'b00, 1'b1, 32'h0);
    tick();
    checks++; if (ch_valid !== 4'b0100 || ch_wstrb !== 4'b0010) begin errors++; $display("FAIL rb_next_ch: got %b/%b want 0100/0010", ch_valid, ch_wstrb); end
    ch_ready = 4'b0100;
    ch_rdata[95:64] = 32'h0000_AB00;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_00AB) begin errors++; $display("FAIL rb_next_rsp: got %b/%b/%h want 1/0/000000ab", rsp_valid, rsp_err, rsp_rdata); end
    ch_ready = '0;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
